// File: rtl/lane_sync_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lane_sync_pkg
// Shared definitions for the lane_sync_ctrl receive sequencing controller:
//   COM_SYM  - comma symbol used for byte alignment
//   state_t  - controller state encoding (SEARCH, SLIP, ACTIVE)
//   CNT_W    - width of every internal counter
// -----------------------------------------------------------------------------
package lane_sync_pkg;

    localparam logic [7:0] COM_SYM = 8'hBC;
    localparam int         CNT_W   = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/lane_sync_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   i_clk    - clock, all logic on its rising edge
//   i_rst_n  - synchronous active-low reset, clears the count
//   i_clr    - synchronous clear (wins over i_inc)
//   i_inc    - increment request
//   o_count  - current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count register: reset/clear to zero, increment until saturated.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= ZERO;
        end else if (i_clr) begin
            r_count <= ZERO;
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/lane_sync_ctrl.sv
// -----------------------------------------------------------------------------
// lane_sync_ctrl
// Receive-side byte-alignment controller for a serial-to-parallel deserializer.
// Counts consecutive COM symbols to acquire lock, requests bit slips while
// unaligned, forwards non-COM bytes when locked and drops lock on byte-strobe
// loss or forced resync.
// Ports:
//   clk_4f       - byte-rate clock
//   reset        - synchronous active-low reset
//   byte_in      - byte from the deserializer
//   byte_valid   - byte_in carries a new byte
//   force_resync - single-cycle request to drop lock
//   slip_req     - one-cycle bit-slip pulse to the deserializer
//   sync_ok      - high while locked (ACTIVE)
//   data_out     - forwarded data byte
//   data_valid   - data_out valid this cycle
//   slip_cnt     - (LANE_SYNC_STATS_EN only) saturating count of slip pulses
//   loss_cnt     - (LANE_SYNC_STATS_EN only) saturating count of lock losses
// Optional feature macro: LANE_SYNC_STATS_EN
// -----------------------------------------------------------------------------
module lane_sync_ctrl
    import lane_sync_pkg::*;
#(
    parameter int COM_COUNT    = 4,
    parameter int SLIP_TIMEOUT = 16,
    parameter int SLIP_HOLDOFF = 8,
    parameter int LOSS_CYCLES  = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       force_resync,
    output logic       slip_req,
    output logic       sync_ok,
    output logic [7:0] data_out,
`ifdef LANE_SYNC_STATS_EN
    output logic [7:0] slip_cnt,
    output logic [7:0] loss_cnt,
`endif
    output logic       data_valid
);

    // Thresholds are compared against the current count, one below the limit,
    // so the event fires on the edge where the count would reach the limit.
    localparam logic [CNT_W-1:0] COM_LAST  = CNT_W'(COM_COUNT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(SLIP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(SLIP_HOLDOFF - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CYCLES - 1);

    state_t     r_state;
    logic       r_slip_req;
    logic       r_sync_ok;
    logic [7:0] r_data_out;
    logic       r_data_valid;

    logic [CNT_W-1:0] w_com_cnt;
    logic [CNT_W-1:0] w_tmr;
    logic [CNT_W-1:0] w_hold;
    logic [CNT_W-1:0] w_gap;

    logic w_com;
    logic w_lock;
    logic w_slip;
    logic w_hold_done;
    logic w_loss;

    // State-dependent events derived from the current counts and inputs.
    always_comb begin
        w_com       = byte_valid && (byte_in == COM_SYM);
        w_lock      = 1'b0;
        w_slip      = 1'b0;
        w_hold_done = 1'b0;
        w_loss      = 1'b0;
        case (r_state)
            SEARCH: begin
                w_lock = w_com && (w_com_cnt == COM_LAST);
                // An accepted COM clears the timer, so it pre-empts a slip.
                w_slip = !w_com && (w_tmr == TO_LAST);
            end
            SLIP: begin
                w_hold_done = (w_hold == HO_LAST);
            end
            ACTIVE: begin
                w_loss = !byte_valid && (w_gap == LOSS_LAST);
            end
            default: begin
                w_lock = 1'b0;
            end
        endcase
    end

    logic w_in_search;
    logic w_in_slip;
    logic w_in_active;
    assign w_in_search = (r_state == SEARCH);
    assign w_in_slip   = (r_state == SLIP);
    assign w_in_active = (r_state == ACTIVE);

    // Each counter is held at zero outside the state that owns it, so it
    // always starts from zero when that state is entered.
    logic w_com_clr, w_com_inc, w_tmr_clr, w_tmr_inc;
    logic w_hold_clr, w_hold_inc, w_gap_clr, w_gap_inc;
    assign w_com_clr  = force_resync | !w_in_search | (byte_valid & !w_com) | w_lock | w_slip;
    assign w_com_inc  = w_in_search & w_com;
    assign w_tmr_clr  = force_resync | !w_in_search | w_com | w_slip;
    assign w_tmr_inc  = w_in_search & !w_com;
    assign w_hold_clr = force_resync | !w_in_slip | w_hold_done;
    assign w_hold_inc = w_in_slip;
    assign w_gap_clr  = force_resync | !w_in_active | byte_valid | w_loss;
    assign w_gap_inc  = w_in_active & !byte_valid;

    sat_counter #(.WIDTH(CNT_W)) u_com_cnt (
        .i_clk(clk_4f), .i_rst_n(reset), .i_clr(w_com_clr), .i_inc(w_com_inc), .o_count(w_com_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_slip_tmr (
        .i_clk(clk_4f), .i_rst_n(reset), .i_clr(w_tmr_clr), .i_inc(w_tmr_inc), .o_count(w_tmr)
    );
    sat_counter #(.WIDTH(CNT_W)) u_hold_tmr (
        .i_clk(clk_4f), .i_rst_n(reset), .i_clr(w_hold_clr), .i_inc(w_hold_inc), .o_count(w_hold)
    );
    sat_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .i_clk(clk_4f), .i_rst_n(reset), .i_clr(w_gap_clr), .i_inc(w_gap_inc), .o_count(w_gap)
    );

`ifdef LANE_SYNC_STATS_EN
    logic w_slip_evt;
    logic w_loss_evt;
    assign w_slip_evt = !force_resync & w_slip;
    assign w_loss_evt = w_in_active & (force_resync | w_loss);

    sat_counter #(.WIDTH(8)) u_slip_stat (
        .i_clk(clk_4f), .i_rst_n(reset), .i_clr(1'b0), .i_inc(w_slip_evt), .o_count(slip_cnt)
    );
    sat_counter #(.WIDTH(8)) u_loss_stat (
        .i_clk(clk_4f), .i_rst_n(reset), .i_clr(1'b0), .i_inc(w_loss_evt), .o_count(loss_cnt)
    );
`endif

    // Controller FSM with registered outputs; force_resync outranks all events.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state      <= SEARCH;
            r_slip_req   <= 1'b0;
            r_sync_ok    <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
        end else if (force_resync) begin
            r_state      <= SEARCH;
            r_slip_req   <= 1'b0;
            r_sync_ok    <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    r_slip_req   <= 1'b0;
                    r_data_valid <= 1'b0;
                    if (w_lock) begin
                        r_state   <= ACTIVE;
                        r_sync_ok <= 1'b1;
                    end else if (w_slip) begin
                        r_state    <= SLIP;
                        r_slip_req <= 1'b1;
                    end else begin
                        r_state <= SEARCH;
                    end
                end
                SLIP: begin
                    r_slip_req <= 1'b0;
                    if (w_hold_done) begin
                        r_state <= SEARCH;
                    end else begin
                        r_state <= SLIP;
                    end
                end
                ACTIVE: begin
                    if (w_loss) begin
                        r_state      <= SEARCH;
                        r_sync_ok    <= 1'b0;
                        r_data_valid <= 1'b0;
                    end else if (byte_valid && !w_com) begin
                        r_data_out   <= byte_in;
                        r_data_valid <= 1'b1;
                    end else begin
                        // COM while locked is idle fill; data_out keeps its value.
                        r_data_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= SEARCH;
                    r_slip_req   <= 1'b0;
                    r_sync_ok    <= 1'b0;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

    assign slip_req   = r_slip_req;
    assign sync_ok    = r_sync_ok;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule
